// File: rtl/detect_pkg.sv
// Shared defaults and types for the 1101 detection event capture block.
package detect_pkg;

   localparam int DET_DEPTH = 4;
   localparam int DET_POS_W = 8;
   localparam int DET_CNT_W = 8;

   typedef logic [DET_POS_W-1:0] det_pos_t;

endpackage

// File: rtl/detect_event_fifo_if.sv
// Valid/ready event channel carrying the bit position of each captured detection.
interface detect_event_fifo_if
   import detect_pkg::*;
#(
   parameter int POS_W = DET_POS_W
);

   logic             ev_valid;
   logic             ev_ready;
   logic [POS_W-1:0] ev_pos;

   modport master (
      output ev_valid,
      output ev_pos,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_pos,
      output ev_ready
   );

endinterface

// File: rtl/event_fifo.sv
// Show-ahead synchronous FIFO; head data is driven from storage and the read pointer only.
module event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_push, do_pop;

   assign empty = (level_q == '0);
   assign full  = (level_q == (AW+1)'(DEPTH));
   assign level = level_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   // A pop in the same cycle frees the slot a full-FIFO push needs.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/detect_event_fifo.sv
// Captures the bit position of each 1101 detection into a FIFO, with a saturating
// detection count and a sticky overflow flag.
module detect_event_fifo
   import detect_pkg::*;
#(
   parameter int DEPTH = DET_DEPTH,
   parameter int POS_W = DET_POS_W,
   parameter int CNT_W = DET_CNT_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      bit_valid,
   input  logic                      detect,
   detect_event_fifo_if.master       ev_if,
   output logic [CNT_W-1:0]          ev_count,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      overflow
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic [POS_W-1:0] pos_q, pos_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             push_req;
   logic             pop_ok;
   logic             fifo_full, fifo_empty;

   assign push_req = bit_valid && detect;
   assign pop_ok   = ev_if.ev_ready && !fifo_empty;

   event_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (POS_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .push  (push_req),
      .pop   (ev_if.ev_ready),
      .din   (pos_q),
      .dout  (ev_if.ev_pos),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign ev_if.ev_valid = !fifo_empty;
   assign ev_count       = cnt_q;
   assign overflow       = ovf_q;

   // The stored position is the index of the completing bit, i.e. before increment.
   always_comb begin
      pos_d = pos_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clear) begin
         pos_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else begin
         if (bit_valid) pos_d = pos_q + 1'b1;
         if (push_req)  cnt_d = sat_inc(cnt_q);
         if (push_req && fifo_full && !pop_ok) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         pos_q <= pos_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

endmodule

// File: tb/tb_detect_event_fifo.sv
// Directed bench for detect_event_fifo with a queue-based reference model.
module tb_detect_event_fifo;
   import detect_pkg::*;

   localparam int DEPTH = 4;
   localparam int POS_W = 8;
   localparam int CNT_W = 8;
   localparam int POS_MOD = 2 ** POS_W;
   localparam int CNT_MAX = 2 ** CNT_W - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clear = 1'b0;
   logic             bit_valid = 1'b0;
   logic             detect = 1'b0;
   logic [CNT_W-1:0] ev_count;
   logic [2:0]       fifo_level;
   logic             overflow;

   detect_event_fifo_if #(.POS_W(POS_W)) ev_if();

   detect_event_fifo #(
      .DEPTH (DEPTH),
      .POS_W (POS_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .bit_valid  (bit_valid),
      .detect     (detect),
      .ev_if      (ev_if.master),
      .ev_count   (ev_count),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   bit cmp_en = 1'b0;

   int m_q[$];
   int m_pos = 0;
   int m_cnt = 0;
   bit m_ovf = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a bounded queue of positions plus plain counters.
   always @(posedge clk or posedge rst) begin : model
      bit pop_now;
      if (rst || clear) begin
         m_q.delete();
         m_pos = 0;
         m_cnt = 0;
         m_ovf = 1'b0;
      end else begin
         pop_now = ev_if.ev_ready && (m_q.size() > 0);
         if (pop_now) void'(m_q.pop_front());
         if (bit_valid && detect) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            if (m_q.size() < DEPTH) m_q.push_back(m_pos);
            else m_ovf = 1'b1;
         end
         if (bit_valid) m_pos = (m_pos + 1) % POS_MOD;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_ev_valid", ev_if.ev_valid, (m_q.size() > 0) ? 1 : 0);
         chk("m_ev_pos", ev_if.ev_pos, (m_q.size() > 0) ? m_q[0] : 0);
         chk("m_fifo_level", fifo_level, m_q.size());
         chk("m_ev_count", ev_count, m_cnt);
         chk("m_overflow", overflow, m_ovf);
      end
   end

   task automatic cyc(input bit bv, input bit det, input bit rdy, input bit clr);
      bit_valid = bv;
      detect = det;
      ev_if.ev_ready = rdy;
      clear = clr;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int exp3[4];
      ev_if.ev_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ev_valid", ev_if.ev_valid, 0);
      chk("rst_ev_pos", ev_if.ev_pos, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_count", ev_count, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b0;
      cmp_en = 1'b1;

      // 1101101 with detections at bits 3 and 6
      for (int i = 0; i < 7; i++) cyc(1'b1, (i == 3) || (i == 6), 1'b0, 1'b0);
      chk("t1_level", fifo_level, 2);
      chk("t1_pos_head", ev_if.ev_pos, 3);
      chk("t1_count", ev_count, 2);
      chk("t1_overflow", overflow, 0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_pos_second", ev_if.ev_pos, 6);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t1_empty", ev_if.ev_valid, 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // five detections into a four-entry FIFO
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t2_level", fifo_level, 4);
      chk("t2_overflow", overflow, 1);
      chk("t2_count", ev_count, 5);
      for (int i = 0; i < 4; i++) begin
         chk("t2_pop_pos", ev_if.ev_pos, i);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("t2_empty", ev_if.ev_valid, 0);
      chk("t2_overflow_sticky", overflow, 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);

      // full FIFO with simultaneous push (position 9) and pop
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cyc(1'b1, i >= 5, 1'b0, 1'b0);
      chk("t3_full_level", fifo_level, 4);
      cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t3_level", fifo_level, 4);
      chk("t3_overflow", overflow, 0);
      exp3 = '{6, 7, 8, 9};
      for (int i = 0; i < 4; i++) begin
         chk("t3_pop_pos", ev_if.ev_pos, exp3[i]);
         cyc(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("t3_empty", ev_if.ev_valid, 0);

      // position wrap, then detect without bit_valid
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (256) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t4_wrap_pos", ev_if.ev_pos, 0);
      chk("t4_wrap_valid", ev_if.ev_valid, 1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4_nobv_count", ev_count, 1);
      chk("t4_nobv_level", fifo_level, 1);

      // count saturation, then clear racing a push
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (300) cyc(1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_sat_count", ev_count, 255);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("t5_clr_valid", ev_if.ev_valid, 0);
      chk("t5_clr_pos", ev_if.ev_pos, 0);
      chk("t5_clr_count", ev_count, 0);
      chk("t5_clr_level", fifo_level, 0);
      chk("t5_clr_overflow", overflow, 0);

      // asynchronous reset mid-cycle with three entries stored
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_level_before", fifo_level, 3);
      bit_valid = 1'b0;
      detect = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_valid", ev_if.ev_valid, 0);
      chk("t6_async_level", fifo_level, 0);
      chk("t6_async_count", ev_count, 0);
      chk("t6_async_overflow", overflow, 0);
      @(negedge clk);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t6_after_valid", ev_if.ev_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/detect_event_fifo.md
Name: detect_event_fifo

Overview:
- Downstream consumer of the serial 1101 Mealy detector.
- Tracks the bit position of every input bit the detector consumes. Captures the position of each detection into a small show-ahead FIFO.
- Presents captured positions to a downstream reader over a valid/ready handshake. Also keeps a saturating total detection count and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2
- POS_W, 8, width of bit-position counter and stored position
- CNT_W, 8, width of saturating total detection counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous clear of counters, FIFO and flags
- bit_valid  in  1  detector consumed one input bit this cycle
- detect  in  1  detector output o; meaningful only when bit_valid=1
- ev_ready  in  1  downstream accepts head event this cycle
- ev_valid  out  1  FIFO non-empty; ev_pos is valid
- ev_pos  out  POS_W  bit position of the oldest unread detection
- ev_count  out  CNT_W  total detections since reset/clear, saturating
- fifo_level  out  $clog2(DEPTH)+1  number of stored entries
- overflow  out  1  sticky; a detection was dropped because the FIFO was full

Behaviour:
- Reset (rst=1, asynchronous) forces the following:
  - position counter = 0, ev_count = 0, fifo_level = 0
  - ev_valid = 0, ev_pos = 0, overflow = 0
  - FIFO pointers = 0
- clear=1 at a rising edge has the same effect as reset on that edge.
  - clear has priority over push, pop and count updates in the same cycle.
- Position counter:
  - increments by 1 on every edge with bit_valid=1
  - wraps from 2^POS_W-1 to 0; no flag on wrap
- Push: bit_valid=1 and detect=1 at an edge.
  - The value written is the current position, i.e. the index of the bit that completed the pattern, taken before the increment.
  - detect=1 with bit_valid=0 is ignored: no push, no count.
- ev_count:
  - increments on every push request, whether accepted or dropped
  - saturates at 2^CNT_W-1
- Pop: ev_valid=1 and ev_ready=1 at an edge.
  - ev_ready while empty has no effect.
- Show-ahead output:
  - ev_pos is the head entry whenever ev_valid=1; ev_pos = 0 when empty.
  - ev_valid and ev_pos come from registers or pointers only; no combinational path from ev_ready.
- Latency:
  - push at edge N -> ev_valid=1 and ev_pos updated after edge N, when previously empty
  - pop at edge N -> next entry presented after edge N
- Simultaneous push and pop:
  - When non-empty, both are performed and fifo_level is unchanged.
  - When full, the pop frees a slot, the push is accepted and overflow is not set.
  - When empty, no pop occurs and the push is accepted.
- Full with push and no pop: the event is dropped, overflow is set to 1 and held until rst/clear, FIFO contents are unchanged, and ev_count still increments.
- Pointers wrap modulo DEPTH. fifo_level ranges over 0..DEPTH.
- ev_valid = (fifo_level != 0).
- Asserting rst mid-stream discards all stored events immediately, with no further pops.

Decomposition:
- detect_pkg holds:
  - localparam defaults DET_DEPTH=4, DET_POS_W=8, DET_CNT_W=8
  - typedef logic [DET_POS_W-1:0] det_pos_t
- One sub-module, event_fifo: parameterised DEPTH×WIDTH show-ahead synchronous FIFO with push, pop, full, empty, level and head data.
  - Push while full is ignored unless a simultaneous pop occurs.
- The top level holds the position counter, saturating ev_count, overflow flag, push/pop qualification and clear.

Test Plan:
- Drive 1101101 serially with bit_valid=1 each cycle and detect pulses at positions 3 and 6, ev_ready=0. Required response: fifo_level=2, ev_pos=3, ev_count=2, overflow=0. Then ev_ready=1 for 2 cycles: ev_pos 3 then 6, then ev_valid=0.
- Drive 5 detections at positions 0..4 with ev_ready=0 and DEPTH=4. Required response: fifo_level=4, overflow=1, ev_count=5, and pops return 0,1,2,3 only.
- Fill to full, then assert push and pop in the same cycle with detection at position 9. Required response: overflow stays 0, fifo_level=4, and the pop order ends with 9.
- Hold bit_valid for 256 cycles with POS_W=8 and assert detect at the 257th bit. Required response: ev_pos=0 (wrap). Also pulse detect with bit_valid=0: no push, ev_count unchanged.
- Force 300 detections with CNT_W=8. Required response: ev_count saturates at 255. Then pulse clear together with a push: all outputs return to 0 and no entry is stored.
- Assert rst asynchronously mid-cycle with 3 entries stored. Required response: ev_valid, fifo_level, ev_count and overflow go to 0 immediately, before the next clk edge.
